// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// multicycle_alu : handshaked ALU, single-cycle ops plus iterative divide/mod
// Revision 1.0
// ============================================================================
module multicycle_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [4:0]       alu_option,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] quo, rem, divisor;
    logic [WIDTH-1:0] quo_next, rem_next, div_out;
    logic [WIDTH:0]   partial, trial;
    logic [CW-1:0]    count;
    logic             is_mod;

    logic             accept, div_start;
    logic [WIDTH:0]   sum, diff;
    logic             shift_big;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_ovf, alu_dbz;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    // A zero divisor is resolved immediately, so only real divisions iterate
    assign div_start = accept && (alu_option == 5'd2 || alu_option == 5'd13)
                       && (op2 != '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = div_start ? DIV : DONE;
            DIV:     if (count == LAST_STEP) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle results, evaluated on the live request at acceptance
    always_comb begin
        sum       = {1'b0, op1} + {1'b0, op2};
        diff      = {1'b0, op2} - {1'b0, op1};
        shift_big = (op1 >= WIDTH'(WIDTH));
        alu_res   = '1;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_dbz   = 1'b0;
        case (alu_option)
            5'd0: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            5'd1: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op2[WIDTH-1]);
            end
            5'd2:  alu_dbz = 1'b1;
            5'd3:  alu_res = op1 & op2;
            5'd4:  alu_res = op1 | op2;
            5'd5:  alu_res = op1 ^ op2;
            5'd6:  alu_res = {{(WIDTH-1){1'b0}}, ^op1};
            5'd7:  alu_res = op1;
            5'd8:  alu_res = (op1 != '0) ? '0 : '1;
            5'd9:  alu_res = (op1 == '0) ? '0 : '1;
            5'd10: alu_res = (op1[WIDTH-1] || op1 == '0) ? '0 : '1;
            5'd11: alu_res = shift_big ? '0 : (op2 << op1);
            5'd12: alu_res = '0;
            5'd13: begin
                alu_res = op1;
                alu_dbz = 1'b1;
            end
            5'd14: alu_res = shift_big ? {WIDTH{op2[WIDTH-1]}} : WIDTH'($signed(op2) >>> op1);
            default: alu_res = '1;
        endcase
    end

    // One restoring-division step: shift in next dividend bit, try subtract
    always_comb begin
        partial = {rem, quo[WIDTH-1]};
        trial   = partial - {1'b0, divisor};
        if (trial[WIDTH]) begin
            rem_next = partial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
        div_out = is_mod ? rem_next : quo_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result      <= '1;
            zero        <= 1'b0;
            carry       <= 1'b0;
            overflow    <= 1'b0;
            negative    <= 1'b1;
            div_by_zero <= 1'b0;
            quo         <= '0;
            rem         <= '0;
            divisor     <= '0;
            count       <= '0;
            is_mod      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        quo     <= op1;
                        rem     <= '0;
                        divisor <= op2;
                        is_mod  <= (alu_option == 5'd13);
                        count   <= '0;
                    end else if (accept) begin
                        result      <= alu_res;
                        zero        <= (alu_res == '0);
                        negative    <= alu_res[WIDTH-1];
                        carry       <= alu_carry;
                        overflow    <= alu_ovf;
                        div_by_zero <= alu_dbz;
                    end
                end
                DIV: begin
                    quo   <= quo_next;
                    rem   <= rem_next;
                    count <= count + CW'(1);
                    if (count == LAST_STEP) begin
                        result      <= div_out;
                        zero        <= (div_out == '0);
                        negative    <= div_out[WIDTH-1];
                        carry       <= 1'b0;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
